// File: rtl/rx_bit_sequencer.sv
// USB RX bit-level sequencer: drops stuff bits, assembles LSB-first bytes,
// counts bytes per packet and flags stuff, alignment and overflow errors.
module rx_bit_sequencer #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              shift_enable,
  input  logic              d_orig,
  input  logic              d_stuff,
  input  logic              eop,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_ready,
  output logic [6:0]        byte_cnt,
  output logic              busy,
  output logic              pkt_done,
  output logic              stuff_err,
  output logic              align_err,
  output logic              ovf_err
);

  typedef enum logic [1:0] {IDLE, RECV, ERR} state_t;

  localparam logic [6:0] MAX_CNT  = 7'(MAX_BYTES);
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              pkt_done_q, pkt_done_d;
  logic              stuff_err_q, stuff_err_d;
  logic              align_err_q, align_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_ready_d = 1'b0;
    pkt_done_d   = 1'b0;
    stuff_err_d  = stuff_err_q;
    align_err_d  = align_err_q;
    ovf_err_d    = ovf_err_q;
    shifted      = {d_orig, shift_q[DATA_W-1:1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RECV;
          shift_d     = '0;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          stuff_err_d = 1'b0;
          align_err_d = 1'b0;
          ovf_err_d   = 1'b0;
        end
      end
      RECV: begin
        // EOP outranks any bit strobed in the same cycle
        if (eop) begin
          state_d = IDLE;
          if (bit_cnt_q == '0) pkt_done_d  = 1'b1;
          else                 align_err_d = 1'b1;
        end else if (shift_enable && d_stuff) begin
          if (d_orig) begin
            stuff_err_d = 1'b1;
            state_d     = ERR;
          end
        end else if (shift_enable) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            if (byte_cnt_q == MAX_CNT) begin
              ovf_err_d = 1'b1;
              state_d   = ERR;
            end else begin
              rx_byte_d    = shifted;
              byte_ready_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + 7'd1;
            end
          end
        end
      end
      ERR: begin
        if (eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      pkt_done_q   <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      pkt_done_q   <= pkt_done_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_ready = byte_ready_q;
  assign byte_cnt   = byte_cnt_q;
  assign busy       = busy_q;
  assign pkt_done   = pkt_done_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Self-checking bench for rx_bit_sequencer: table-driven packets with a
// byte scoreboard, plus hand-written stuff, priority, overflow and reset cases.
module tb_rx_bit_sequencer;

  localparam int MaxB = 2;

  logic       clk;
  logic       nrst;
  logic       start;
  logic       shiftEnable;
  logic       dOrig;
  logic       dStuff;
  logic       eop;
  logic [7:0] rxByte;
  logic       byteReady;
  logic [6:0] byteCnt;
  logic       busy;
  logic       pktDone;
  logic       stuffErr;
  logic       alignErr;
  logic       ovfErr;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  typedef struct {
    int          nBits;
    logic [31:0] bits;
    logic [31:0] stuffMask;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    logic [6:0]  expCnt;
    logic        expDone;
    logic        expAlign;
  } vecT;

  vecT vecs[6];

  rx_bit_sequencer #(.DATA_W(8), .MAX_BYTES(MaxB)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .shift_enable(shiftEnable),
    .d_orig      (dOrig),
    .d_stuff     (dStuff),
    .eop         (eop),
    .rx_byte     (rxByte),
    .byte_ready  (byteReady),
    .byte_cnt    (byteCnt),
    .busy        (busy),
    .pkt_done    (pktDone),
    .stuff_err   (stuffErr),
    .align_err   (alignErr),
    .ovf_err     (ovfErr)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a wedged run still ends with a visible failure
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every byte_ready pops the next expected byte
  always @(negedge clk) begin
    if (nrst && byteReady) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_unexpected: byte_ready with rx_byte 0x%0h, none expected", rxByte);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        if (rxByte !== e) begin
          errors++;
          $display("[TB] FAIL scoreboard_byte: got 0x%0h expected 0x%0h", rxByte, e);
        end
      end
    end
  end

  // Drives nBits strobes, one every other cycle, pushing expected bytes and
  // checking byte_ready both in the cycle after each strobe and in the gap.
  task automatic applyStimulus(input logic [31:0] bits, input logic [31:0] stuffMask,
                               input int nBits, input logic [7:0] exp0,
                               input logic [7:0] exp1, input int maxAccepted);
    int   dataBits;
    int   bytesDone;
    logic expReady;
    dataBits  = 0;
    bytesDone = 0;
    for (int i = 0; i < nBits; i++) begin
      shiftEnable = 1'b1;
      dOrig       = bits[i];
      dStuff      = stuffMask[i];
      expReady    = 1'b0;
      if (!stuffMask[i]) begin
        dataBits++;
        if (dataBits % 8 == 0) begin
          if (bytesDone < maxAccepted) begin
            expReady = 1'b1;
            expQ.push_back(bytesDone == 0 ? exp0 : exp1);
          end
          bytesDone++;
        end
      end
      @(negedge clk);
      shiftEnable = 1'b0;
      dOrig       = 1'b0;
      dStuff      = 1'b0;
      checkOutput("byte_ready_strobe", {7'b0, byteReady}, {7'b0, expReady});
      @(negedge clk);
      checkOutput("byte_ready_gap", {7'b0, byteReady}, 8'h00);
    end
  endtask

  task automatic startPkt();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_busy", {7'b0, busy}, 8'h01);
    checkOutput("start_byte_cnt", {1'b0, byteCnt}, 8'h00);
    checkOutput("start_flags", {5'b0, stuffErr, alignErr, ovfErr}, 8'h00);
  endtask

  task automatic endPkt(input logic expDone, input logic expAlign, input logic [6:0] expCnt);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    checkOutput("eop_pkt_done", {7'b0, pktDone}, {7'b0, expDone});
    checkOutput("eop_align_err", {7'b0, alignErr}, {7'b0, expAlign});
    checkOutput("eop_byte_cnt", {1'b0, byteCnt}, {1'b0, expCnt});
    checkOutput("eop_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    checkOutput("pkt_done_single", {7'b0, pktDone}, 8'h00);
  endtask

  initial begin
    // nBits, bits (strobe i = bit i), stuff mask, exp bytes, cnt, done, align
    vecs[0] = '{8,  32'h0000_00A5, 32'h0, 8'hA5, 8'h00, 7'd1, 1'b1, 1'b0};
    vecs[1] = '{9,  32'h0000_00BF, 32'h40, 8'h7F, 8'h00, 7'd1, 1'b1, 1'b0};
    vecs[2] = '{16, 32'h0000_813C, 32'h0, 8'h3C, 8'h81, 7'd2, 1'b1, 1'b0};
    vecs[3] = '{5,  32'h0000_000D, 32'h0, 8'h00, 8'h00, 7'd0, 1'b0, 1'b1};
    vecs[4] = '{11, 32'h0000_075A, 32'h0, 8'h5A, 8'h00, 7'd1, 1'b0, 1'b1};
    vecs[5] = '{0,  32'h0,         32'h0, 8'h00, 8'h00, 7'd0, 1'b1, 1'b0};

    nrst = 1'b0; start = 1'b0; shiftEnable = 1'b0; dOrig = 1'b0; dStuff = 1'b0; eop = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rx_byte", rxByte, 8'h00);
    checkOutput("reset_outputs", {busy, byteReady, pktDone, stuffErr, alignErr, ovfErr, 2'b0}, 8'h00);
    checkOutput("reset_byte_cnt", {1'b0, byteCnt}, 8'h00);
    nrst = 1'b1;
    @(negedge clk);

    $display("[TB] table-driven packets");
    for (int v = 0; v < 6; v++) begin
      startPkt();
      applyStimulus(vecs[v].bits, vecs[v].stuffMask, vecs[v].nBits, vecs[v].exp0, vecs[v].exp1, MaxB);
      endPkt(vecs[v].expDone, vecs[v].expAlign, vecs[v].expCnt);
      checkOutput("table_stuff_err", {7'b0, stuffErr}, 8'h00);
      checkOutput("table_queue_empty", 8'(expQ.size()), 8'h00);
    end

    $display("[TB] stuff error sequence");
    startPkt();
    applyStimulus(32'h0000_000F, 32'h0000_0008, 4, 8'h00, 8'h00, MaxB);
    checkOutput("stuff_err_set", {7'b0, stuffErr}, 8'h01);
    checkOutput("stuff_err_busy", {7'b0, busy}, 8'h01);
    applyStimulus(32'h0000_00FF, 32'h0, 8, 8'h00, 8'h00, 0);
    endPkt(1'b0, 1'b0, 7'd0);
    checkOutput("stuff_err_sticky", {7'b0, stuffErr}, 8'h01);
    startPkt();
    endPkt(1'b1, 1'b0, 7'd0);

    $display("[TB] eop coincident with strobe");
    startPkt();
    applyStimulus(32'h0000_007F, 32'h0, 7, 8'h00, 8'h00, MaxB);
    eop = 1'b1; shiftEnable = 1'b1; dOrig = 1'b1;
    @(negedge clk);
    eop = 1'b0; shiftEnable = 1'b0; dOrig = 1'b0;
    checkOutput("coinc_pkt_done", {7'b0, pktDone}, 8'h00);
    checkOutput("coinc_align_err", {7'b0, alignErr}, 8'h01);
    checkOutput("coinc_byte_cnt", {1'b0, byteCnt}, 8'h00);
    checkOutput("coinc_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    checkOutput("coinc_no_byte", {7'b0, byteReady}, 8'h00);

    $display("[TB] overflow sequence");
    startPkt();
    applyStimulus(32'h0033_2211, 32'h0, 24, 8'h11, 8'h22, MaxB);
    checkOutput("ovf_err_set", {7'b0, ovfErr}, 8'h01);
    checkOutput("ovf_byte_cnt", {1'b0, byteCnt}, 8'h02);
    checkOutput("ovf_rx_byte_held", rxByte, 8'h22);
    checkOutput("ovf_busy", {7'b0, busy}, 8'h01);
    applyStimulus(32'h0000_0044, 32'h0, 8, 8'h00, 8'h00, 0);
    checkOutput("ovf_still_busy", {7'b0, busy}, 8'h01);
    endPkt(1'b0, 1'b0, 7'd2);
    checkOutput("ovf_sticky", {7'b0, ovfErr}, 8'h01);
    startPkt();
    endPkt(1'b1, 1'b0, 7'd0);

    $display("[TB] async reset mid-packet");
    startPkt();
    applyStimulus(32'h0000_0BC3, 32'h0, 12, 8'hC3, 8'h00, MaxB);
    #2 nrst = 1'b0;
    #1;
    checkOutput("async_rx_byte", rxByte, 8'h00);
    checkOutput("async_byte_cnt", {1'b0, byteCnt}, 8'h00);
    checkOutput("async_outputs", {busy, byteReady, pktDone, stuffErr, alignErr, ovfErr, 2'b0}, 8'h00);
    @(negedge clk);
    checkOutput("async_no_pkt_done", {7'b0, pktDone}, 8'h00);
    nrst = 1'b1;
    @(negedge clk);
    startPkt();
    applyStimulus(32'h0000_0096, 32'h0, 8, 8'h96, 8'h00, MaxB);
    endPkt(1'b1, 1'b0, 7'd1);
    checkOutput("final_rx_byte", rxByte, 8'h96);
    checkOutput("final_queue_empty", 8'(expQ.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_bit_sequencer.md
Name: rx_bit_sequencer

Overview:
Bit-level receive controller for the USB RX path. It sits between the NRZI decoder / stuff-bit detector and the byte-level RX FSM. Each bit strobe, it either discards a stuff bit or shifts the bit into a byte register. It counts bits and bytes, reports completed bytes, and flags stuff, alignment and overflow errors. It sequences one packet from start to EOP.

Parameters:
DATA_W, 8, bits per received byte (fixed at 8 for USB; bit counter is 3 bits).
MAX_BYTES, 64, max bytes per packet before overflow; byte_cnt width is 7.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: SYNC detected, begin packet
shift_enable  input  1  one-cycle strobe per bit period; d_orig valid
d_orig  input  1  decoded (post-NRZI) bit
d_stuff  input  1  from stuff-bit detector: current strobed bit is a stuff bit (six prior 1s)
eop  input  1  one-cycle pulse: end-of-packet detected
rx_byte  output  8  last completed byte, LSB first on wire
byte_ready  output  1  one-cycle pulse when rx_byte updates
byte_cnt  output  7  bytes completed this packet
busy  output  1  high in RECV and ERR
pkt_done  output  1  one-cycle pulse on clean EOP
stuff_err  output  1  sticky: stuff-bit position held a 1
align_err  output  1  sticky: EOP arrived with partial byte
ovf_err  output  1  sticky: byte beyond MAX_BYTES

Behaviour:
- Reset (async, nrst=0): state=IDLE; rx_byte=0, shift reg=0, bit_cnt=0, byte_cnt=0; all pulses and sticky flags 0. Reset mid-packet aborts immediately, with no pkt_done.
- States: IDLE, RECV, ERR.
- IDLE:
  - shift_enable, d_orig, d_stuff and eop are ignored.
  - start -> RECV next cycle. In the same edge, clear shift reg, bit_cnt, byte_cnt and the three sticky flags.
- RECV, evaluated on each edge in priority order:
  1. eop=1 (same-cycle shift_enable ignored):
     - bit_cnt==0 -> pkt_done pulse next cycle, go to IDLE.
     - bit_cnt!=0 -> set align_err, go to IDLE, no pkt_done.
  2. shift_enable=1 and d_stuff=1:
     - d_orig=0 -> stuff bit discarded; shift reg and bit_cnt unchanged.
     - d_orig=1 -> set stuff_err, go to ERR.
  3. shift_enable=1 and d_stuff=0:
     - shift reg <= {d_orig, shift[7:1]} (LSB first); bit_cnt increments, wrapping 7->0.
     - On the 8th bit (bit_cnt==7), the following cycle: rx_byte <= completed value, byte_ready=1 for one cycle, byte_cnt++.
     - If byte_cnt==MAX_BYTES when a byte completes: set ovf_err, suppress byte_ready, leave rx_byte and byte_cnt unchanged, go to ERR.
  4. start in RECV is ignored.
- ERR:
  - All inputs except eop are ignored.
  - eop -> IDLE; no pkt_done; sticky flags retained.
- Latency:
  - byte_ready asserts exactly 1 cycle after the strobe carrying bit 8.
  - pkt_done asserts 1 cycle after eop.
- Sticky flags hold until the next accepted start or reset.
- busy = (state != IDLE), registered.
- byte_cnt saturates at MAX_BYTES; it never wraps.

Test Plan:
1. Reset, then start, then 8 strobes of d_orig = 1,0,1,0,0,1,0,1 with d_stuff=0, then eop -> rx_byte=8'hA5, byte_ready single pulse 1 cycle after the 8th strobe, byte_cnt=1, pkt_done pulse, busy falls.
2. Stuff drop:
   - Stimulus: start; strobes 1,1,1,1,1,1, then a strobe with d_stuff=1, d_orig=0; then strobes 1,0; eop.
   - Response: stuff bit not shifted; rx_byte=8'h7F; no stuff_err; pkt_done pulses.
3. Stuff error: strobe with d_stuff=1, d_orig=1 -> stuff_err=1, state ERR, further strobes produce no byte_ready. eop -> IDLE, stuff_err still 1. Next start -> stuff_err=0.
4. Alignment and priority:
   - Stimulus: 5 data bits, then eop coincident with shift_enable.
   - Response: align_err=1, no pkt_done, byte_cnt=0, coincident bit ignored.
5. Overflow: MAX_BYTES=2, send 3 full bytes -> two byte_ready pulses, byte_cnt=2, third byte sets ovf_err with no byte_ready, state ERR until eop.
6. Async reset: drop nrst after bit 4 of the 2nd byte -> all outputs 0 immediately. After release, start plus a clean byte works normally with byte_cnt=1.
